// File: rtl/store_write_buffer.sv
// Store write buffer: formats stores into word-aligned, lane-replicated writes, queues them
// in a small FIFO, drains them to memory in order, and flags loads to words still pending.
module store_write_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         storeValid,
   input  logic [1:0]                   storeSrc,
   input  logic [ADDR_WIDTH-1:0]        storeAddress,
   input  logic [31:0]                  storeData,
   output logic                         storeReady,
   output logic                         misalignErr,
   input  logic                         loadValid,
   input  logic [ADDR_WIDTH-1:0]        loadAddress,
   output logic                         loadHazard,
   output logic                         memValid,
   input  logic                         memReady,
   output logic [ADDR_WIDTH-1:0]        memAddr,
   output logic [31:0]                  memWData,
   output logic [3:0]                   memByteEn,
   output logic                         bufEmpty,
   output logic [$clog2(DEPTH+1)-1:0]   bufCount
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-3:0] entryWord [DEPTH];
   logic [31:0]           entryData [DEPTH];
   logic [3:0]            entryEn   [DEPTH];

   logic [PTR_W-1:0] headPtr;
   logic [PTR_W-1:0] tailPtr;
   logic [CNT_W-1:0] entryCount;

   logic [31:0] fmtData;
   logic [3:0]  fmtEn;
   logic        misaligned;
   logic        enq;
   logic        deq;
   logic        hazardHit;
   logic        unusedLoadLanes;

   // Lane replication and byte-enable generation; code 11 behaves as a word store.
   always_comb begin
      fmtData    = storeData;
      fmtEn      = 4'b1111;
      misaligned = 1'b0;
      case (storeSrc)
         2'b00: begin
            fmtData = {4{storeData[7:0]}};
            fmtEn   = 4'b0001 << storeAddress[1:0];
         end
         2'b01: begin
            fmtData    = {2{storeData[15:0]}};
            fmtEn      = storeAddress[1] ? 4'b1100 : 4'b0011;
            misaligned = storeAddress[0];
         end
         default: begin
            misaligned = |storeAddress[1:0];
         end
      endcase
   end

   assign storeReady = (entryCount != FULL_COUNT);
   assign memValid   = (entryCount != '0);
   assign bufEmpty   = (entryCount == '0);
   assign bufCount   = entryCount;
   assign enq        = storeValid && storeReady && !misaligned;
   assign deq        = memValid && memReady;

   assign memAddr   = {entryWord[headPtr], 2'b00};
   assign memWData  = entryData[headPtr];
   assign memByteEn = entryEn[headPtr];

   // An entry is live when its distance from the head is below the count, so the head
   // entry leaving this cycle still matches and the one being written does not.
   always_comb begin
      hazardHit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(PTR_W'(PTR_W'(i) - headPtr)) < entryCount &&
             entryWord[i] == loadAddress[ADDR_WIDTH-1:2]) begin
            hazardHit = 1'b1;
         end
      end
   end

   assign loadHazard      = loadValid && hazardHit;
   assign unusedLoadLanes = ^loadAddress[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         headPtr     <= '0;
         tailPtr     <= '0;
         entryCount  <= '0;
         misalignErr <= 1'b0;
      end else begin
         misalignErr <= storeValid && misaligned;
         if (enq) begin
            tailPtr <= tailPtr + PTR_W'(1);
         end
         if (deq) begin
            headPtr <= headPtr + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   entryCount <= entryCount + CNT_W'(1);
            2'b01:   entryCount <= entryCount - CNT_W'(1);
            default: entryCount <= entryCount;
         endcase
      end
   end

   // Payload registers need no reset; only the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         entryWord[tailPtr] <= storeAddress[ADDR_WIDTH-1:2];
         entryData[tailPtr] <= fmtData;
         entryEn[tailPtr]   <= fmtEn;
      end
   end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: constant vector table, hand-written corner sequences and a
// random run, all checked against a queue-based model of the buffer.
module tb_store_write_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        storeValid;
   logic [1:0]  storeSrc;
   logic [31:0] storeAddress;
   logic [31:0] storeData;
   logic        storeReady;
   logic        misalignErr;
   logic        loadValid;
   logic [31:0] loadAddress;
   logic        loadHazard;
   logic        memValid;
   logic        memReady;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic [3:0]  memByteEn;
   logic        bufEmpty;
   logic [2:0]  bufCount;

   typedef struct {
      logic [29:0] word;
      logic [31:0] data;
      logic [3:0]  en;
   } entry_t;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] addr;
      logic [31:0] data;
      logic        expValid;
      logic        expMis;
      logic [31:0] expAddr;
      logic [31:0] expData;
      logic [3:0]  expEn;
   } vec_t;

   entry_t modelQ[$];
   bit     modelMis;
   logic   lastHazard;
   int     vectors = 0;
   int     miscompares = 0;
   vec_t   vecs[10];

   store_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .storeValid(storeValid), .storeSrc(storeSrc), .storeAddress(storeAddress),
      .storeData(storeData), .storeReady(storeReady), .misalignErr(misalignErr),
      .loadValid(loadValid), .loadAddress(loadAddress), .loadHazard(loadHazard),
      .memValid(memValid), .memReady(memReady), .memAddr(memAddr), .memWData(memWData),
      .memByteEn(memByteEn), .bufEmpty(bufEmpty), .bufCount(bufCount)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, required);
      end
   endtask

   // Reference formatting from access size: replicate the datum and enable 'bytes' lanes at offset.
   function automatic void formatStore(input logic [1:0] src, input logic [31:0] addr,
                                       input logic [31:0] d, output bit mis, output entry_t e);
      int bytes;
      bytes = (src == 2'b00) ? 1 : (src == 2'b01) ? 2 : 4;
      mis    = (addr % bytes) != 0;
      e.word = addr[31:2];
      e.en   = 4'(((1 << bytes) - 1) << addr[1:0]);
      if (bytes == 1)      e.data = {24'h0, d[7:0]} * 32'h01010101;
      else if (bytes == 2) e.data = {16'h0, d[15:0]} * 32'h00010001;
      else                 e.data = d;
   endfunction

   task automatic checkModel();
      bit hz;
      hz = 1'b0;
      foreach (modelQ[k]) if (modelQ[k].word == loadAddress[31:2]) hz = 1'b1;
      hz = hz && loadValid;
      checkOutput("storeReady", 32'(storeReady), 32'(modelQ.size() < DEPTH));
      checkOutput("memValid", 32'(memValid), 32'(modelQ.size() > 0));
      checkOutput("bufEmpty", 32'(bufEmpty), 32'(modelQ.size() == 0));
      checkOutput("bufCount", 32'(bufCount), 32'(modelQ.size()));
      checkOutput("misalignErr", 32'(misalignErr), 32'(modelMis));
      checkOutput("loadHazard", 32'(loadHazard), 32'(hz));
      if (modelQ.size() > 0) begin
         checkOutput("memAddr", memAddr, {modelQ[0].word, 2'b00});
         checkOutput("memWData", memWData, modelQ[0].data);
         checkOutput("memByteEn", 32'(memByteEn), 32'(modelQ[0].en));
      end
   endtask

   // One clock: drive at the falling edge, check just after, advance the model, return after the rising edge.
   task automatic applyStimulus(input bit sv, input logic [1:0] src, input logic [31:0] addr,
                                input logic [31:0] d, input bit lv, input logic [31:0] la, input bit mr);
      bit     mis, enq, deq;
      entry_t e;
      @(negedge clk);
      storeValid = sv; storeSrc = src; storeAddress = addr; storeData = d;
      loadValid = lv; loadAddress = la; memReady = mr;
      #1;
      checkModel();
      lastHazard = loadHazard;
      formatStore(src, addr, d, mis, e);
      deq = (modelQ.size() > 0) && mr;
      enq = sv && (modelQ.size() < DEPTH) && !mis;
      if (deq) void'(modelQ.pop_front());
      if (enq) modelQ.push_back(e);
      modelMis = sv && mis;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit mr);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, mr);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not finish, required finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{2'b00, 32'h103, 32'h000000AB, 1'b1, 1'b0, 32'h100, 32'hABABABAB, 4'b1000};
      vecs[1] = '{2'b01, 32'h202, 32'h00001234, 1'b1, 1'b0, 32'h200, 32'h12341234, 4'b1100};
      vecs[2] = '{2'b01, 32'h201, 32'h00001234, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000};
      vecs[3] = '{2'b10, 32'h300, 32'hDEADBEEF, 1'b1, 1'b0, 32'h300, 32'hDEADBEEF, 4'b1111};
      vecs[4] = '{2'b10, 32'h302, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000};
      vecs[5] = '{2'b00, 32'h400, 32'h123456CD, 1'b1, 1'b0, 32'h400, 32'hCDCDCDCD, 4'b0001};
      vecs[6] = '{2'b01, 32'h500, 32'hFFFFBEEF, 1'b1, 1'b0, 32'h500, 32'hBEEFBEEF, 4'b0011};
      vecs[7] = '{2'b11, 32'h600, 32'h11223344, 1'b1, 1'b0, 32'h600, 32'h11223344, 4'b1111};
      vecs[8] = '{2'b11, 32'h601, 32'h11223344, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000};
      vecs[9] = '{2'b00, 32'h0A1, 32'h0000005A, 1'b1, 1'b0, 32'h0A0, 32'h5A5A5A5A, 4'b0010};

      reset = 1'b1; storeValid = 1'b0; storeSrc = 2'b00; storeAddress = '0; storeData = '0;
      loadValid = 1'b1; loadAddress = '0; memReady = 1'b0; modelMis = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset storeReady", 32'(storeReady), 32'd1);
      checkOutput("reset memValid", 32'(memValid), 32'd0);
      checkOutput("reset bufEmpty", 32'(bufEmpty), 32'd1);
      checkOutput("reset bufCount", 32'(bufCount), 32'd0);
      checkOutput("reset loadHazard", 32'(loadHazard), 32'd0);
      checkOutput("reset misalignErr", 32'(misalignErr), 32'd0);
      @(negedge clk);
      reset = 1'b0; loadValid = 1'b0;

      // Formatting table: one store into an empty, stalled buffer, then drain.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, vecs[i].src, vecs[i].addr, vecs[i].data, 1'b0, 32'h0, 1'b0);
         checkOutput($sformatf("vec%0d memValid", i), 32'(memValid), 32'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d misalignErr", i), 32'(misalignErr), 32'(vecs[i].expMis));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d memAddr", i), memAddr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d memWData", i), memWData, vecs[i].expData);
            checkOutput($sformatf("vec%0d memByteEn", i), 32'(memByteEn), 32'(vecs[i].expEn));
         end
         idle(1'b1);
         idle(1'b0);
      end

      // Fill to full with memory stalled, then drain in order.
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 2'b10, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 32'h0, 1'b0);
      checkOutput("full bufCount", 32'(bufCount), 32'd4);
      checkOutput("full storeReady", 32'(storeReady), 32'd0);
      applyStimulus(1'b1, 2'b10, 32'h10, 32'hEE, 1'b0, 32'h0, 1'b0);
      checkOutput("full ignore bufCount", 32'(bufCount), 32'd4);
      checkOutput("full head memAddr", memAddr, 32'h0);
      applyStimulus(1'b1, 2'b10, 32'h10, 32'hEE, 1'b0, 32'h0, 1'b1);
      checkOutput("full+drain bufCount", 32'(bufCount), 32'd3);
      checkOutput("drain memAddr 4", memAddr, 32'h4);
      idle(1'b1);
      checkOutput("drain memAddr 8", memAddr, 32'h8);
      idle(1'b1);
      checkOutput("drain memAddr C", memAddr, 32'hC);
      idle(1'b1);
      checkOutput("drained bufEmpty", 32'(bufEmpty), 32'd1);

      // Steady count of two with simultaneous enqueue and dequeue, wrapping pointers.
      applyStimulus(1'b1, 2'b10, 32'h1000, 32'h1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 2'b10, 32'h1004, 32'h2, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 2'b10, 32'h1008 + 32'(4 * k), 32'(k), 1'b0, 32'h0, 1'b1);
         checkOutput($sformatf("steady bufCount %0d", k), 32'(bufCount), 32'd2);
      end
      checkOutput("wrap head memAddr", memAddr, 32'h1020);
      idle(1'b1);
      checkOutput("wrap next memAddr", memAddr, 32'h1024);
      idle(1'b1);
      checkOutput("wrap bufEmpty", 32'(bufEmpty), 32'd1);

      // Load hazard cases.
      applyStimulus(1'b1, 2'b10, 32'h40, 32'h55, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h42, 1'b0);
      checkOutput("hazard 0x42 pending", 32'(lastHazard), 32'd1);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h44, 1'b0);
      checkOutput("hazard 0x44", 32'(lastHazard), 32'd0);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h40, 1'b1);
      checkOutput("hazard leaving entry", 32'(lastHazard), 32'd1);
      applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h42, 1'b0);
      checkOutput("hazard after drain", 32'(lastHazard), 32'd0);
      applyStimulus(1'b1, 2'b10, 32'h80, 32'h66, 1'b1, 32'h80, 1'b0);
      checkOutput("hazard entering entry", 32'(lastHazard), 32'd0);
      idle(1'b1);

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 2'b10, 32'h2000 + 32'(4 * i), 32'(i), 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      storeValid = 1'b0; memReady = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset memValid", 32'(memValid), 32'd0);
      checkOutput("midreset bufCount", 32'(bufCount), 32'd0);
      modelQ.delete();
      modelMis = 1'b0;
      @(negedge clk);
      reset = 1'b0; memReady = 1'b0;
      applyStimulus(1'b1, 2'b10, 32'h3000, 32'h77, 1'b0, 32'h0, 1'b0);
      checkOutput("postreset bufCount", 32'(bufCount), 32'd1);
      checkOutput("postreset memAddr", memAddr, 32'h3000);
      idle(1'b1);
      checkOutput("postreset bufEmpty", 32'(bufEmpty), 32'd1);

      // Random traffic over a small address window so hazards and wraps are frequent.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ra;
         logic [31:0] rl;
         ra = 32'h100 + 32'($urandom_range(0, 23));
         rl = 32'h100 + 32'($urandom_range(0, 23));
         applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom(),
                       1'($urandom_range(0, 1)), rl, ($urandom_range(0, 9) < 6));
      end
      for (int n = 0; n < DEPTH + 1; n++) idle(1'b1);
      idle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
